// File: rtl/rvv_backend_dispatch_bypass_pipe_if.sv
// Operand-bypass stage bus.
// Groups the upstream uop handshake, the ROB snapshot (head, done, data, byte
// types, agnostic fill flags), the per-operand RAW hit vectors, VRF read data,
// and the downstream valid/ready result.
//   slave  : the bypass stage (consumes ROB/VRF/hits, produces out_*)
//   master : the environment driving the stage
interface rvv_backend_dispatch_bypass_pipe_if #(
  parameter int ROB_DEPTH = 8,
  parameter int VLENB     = 16,
  parameter int N_OPN     = 4
);
  localparam int AW   = $clog2(ROB_DEPTH);
  localparam int VLEN = 8*VLENB;

  logic                          flush;
  logic                          in_valid;
  logic                          in_ready;
  logic [AW-1:0]                 rob_head;
  logic [ROB_DEPTH-1:0]          rob_done;
  logic [ROB_DEPTH*VLEN-1:0]     rob_wdata;
  logic [ROB_DEPTH*VLENB*2-1:0]  rob_byte_type;
  logic [ROB_DEPTH-1:0]          rob_inactive_one;
  logic [ROB_DEPTH-1:0]          rob_tail_one;
  logic [N_OPN*ROB_DEPTH-1:0]    opn_hit;
  logic [N_OPN*VLEN-1:0]         vrf_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [N_OPN*VLEN-1:0]         out_data;
  logic [N_OPN-1:0]              out_pending;

  modport slave (
    input  flush, in_valid, rob_head, rob_done, rob_wdata, rob_byte_type,
           rob_inactive_one, rob_tail_one, opn_hit, vrf_data, out_ready,
    output in_ready, out_valid, out_data, out_pending
  );

  modport master (
    output flush, in_valid, rob_head, rob_done, rob_wdata, rob_byte_type,
           rob_inactive_one, rob_tail_one, opn_hit, vrf_data, out_ready,
    input  in_ready, out_valid, out_data, out_pending
  );
endinterface

// File: rtl/rvv_backend_dispatch_bypass_pipe.sv
// Registered operand-bypass stage for RVV dispatch.
// Each operand byte comes from the youngest eligible hitting ROB entry
// (age measured from rob_head, so a wrapped ROB resolves correctly), else from
// VRF read data. One valid/ready register sits between select and issue.
// Ports: clk, rst_n (async low), bus (slave modport: handshake, ROB snapshot,
// hits, VRF data, registered out_data/out_pending).
// Bus packing: entry i data at rob_wdata[i*VLEN +: VLEN]; byte j of entry i
// type at rob_byte_type[(i*VLENB+j)*2 +: 2]; operand k hit on entry i at
// opn_hit[k*ROB_DEPTH+i]; operand k VRF/out data at [k*VLEN +: VLEN].

// Per-operand byte select.
module rvv_backend_dispatch_bypass_opn #(
  parameter  int ROB_DEPTH = 8,
  parameter  int VLENB     = 16,
  localparam int AW        = $clog2(ROB_DEPTH),
  localparam int VLEN      = 8*VLENB
) (
  input  logic [AW-1:0]                rob_head,
  input  logic [ROB_DEPTH-1:0]         hit,
  input  logic [ROB_DEPTH-1:0]         done,
  input  logic [ROB_DEPTH-1:0]         inactive_one,
  input  logic [ROB_DEPTH-1:0]         tail_one,
  input  logic [ROB_DEPTH*VLEN-1:0]    rob_wdata,
  input  logic [ROB_DEPTH*VLENB*2-1:0] byte_type,
  input  logic [VLEN-1:0]              vrf,
  output logic [VLEN-1:0]              data,
  output logic                         pending
);
  typedef enum logic [1:0] {
    BODY_ACTIVE   = 2'd0,
    BODY_INACTIVE = 2'd1,
    TAIL          = 2'd2,
    NOT_CHANGE    = 2'd3
  } byte_type_t;

  // Walk entries oldest to youngest; a later (younger) eligible entry
  // overwrites the byte, so the final value comes from the largest age.
  always_comb begin
    data = vrf;
    for (int a = 0; a < ROB_DEPTH; a++) begin
      logic [AW-1:0] idx;
      idx = rob_head + AW'(a);
      for (int j = 0; j < VLENB; j++) begin
        logic [1:0] bt;
        logic       agn;
        bt  = byte_type[(int'(idx)*VLENB + j)*2 +: 2];
        agn = (bt == BODY_INACTIVE && inactive_one[idx]) ||
              (bt == TAIL          && tail_one[idx]);
        if (hit[idx] && (bt == BODY_ACTIVE || agn))
          data[j*8 +: 8] = agn ? 8'hFF : rob_wdata[int'(idx)*VLEN + j*8 +: 8];
      end
    end
  end

  // Not-done hits still supply data; the consumer decides whether to stall.
  assign pending = |(hit & ~done);
endmodule

module rvv_backend_dispatch_bypass_pipe #(
  parameter int ROB_DEPTH = 8,
  parameter int VLENB     = 16,
  parameter int N_OPN     = 4
) (
  input logic clk,
  input logic rst_n,
  rvv_backend_dispatch_bypass_pipe_if.slave bus
);
  localparam int VLEN = 8*VLENB;

  logic [N_OPN-1:0][VLEN-1:0] sel_data;
  logic [N_OPN-1:0]           sel_pend;
  logic [N_OPN*VLEN-1:0]      data_q;
  logic [N_OPN-1:0]           pend_q;
  logic                       vld_q;
  logic                       load;

  for (genvar k = 0; k < N_OPN; k++) begin : g_opn
    rvv_backend_dispatch_bypass_opn #(
      .ROB_DEPTH (ROB_DEPTH),
      .VLENB     (VLENB)
    ) u_opn (
      .rob_head     (bus.rob_head),
      .hit          (bus.opn_hit[k*ROB_DEPTH +: ROB_DEPTH]),
      .done         (bus.rob_done),
      .inactive_one (bus.rob_inactive_one),
      .tail_one     (bus.rob_tail_one),
      .rob_wdata    (bus.rob_wdata),
      .byte_type    (bus.rob_byte_type),
      .vrf          (bus.vrf_data[k*VLEN +: VLEN]),
      .data         (sel_data[k]),
      .pending      (sel_pend[k])
    );
  end

  // Drain and reload on the same edge keeps 1 uop/cycle; flush does not
  // touch in_ready, it only suppresses the load.
  assign bus.in_ready = !vld_q || bus.out_ready;
  assign load         = bus.in_valid && bus.in_ready && !bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      pend_q <= '0;
    end else begin
      if (bus.flush)         vld_q <= 1'b0;
      else if (load)         vld_q <= 1'b1;
      else if (bus.out_ready) vld_q <= 1'b0;
      if (load) begin
        data_q <= sel_data;
        pend_q <= sel_pend;
      end
    end
  end

  assign bus.out_valid   = vld_q;
  assign bus.out_data    = data_q;
  assign bus.out_pending = pend_q;
endmodule

// File: tb/tb_rvv_backend_dispatch_bypass_pipe.sv
module tb_rvv_backend_dispatch_bypass_pipe;
  localparam int RD = 8;
  localparam int VB = 16;
  localparam int NO = 4;
  localparam int VL = 8*VB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rvv_backend_dispatch_bypass_pipe_if #(.ROB_DEPTH(RD), .VLENB(VB), .N_OPN(NO)) bus ();

  rvv_backend_dispatch_bypass_pipe #(.ROB_DEPTH(RD), .VLENB(VB), .N_OPN(NO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string nm, input logic [NO*VL-1:0] act, input logic [NO*VL-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Reference: for every byte pick the eligible entry of maximum age
  // (age = distance from head), agnostic bytes read as all-ones.
  function automatic void model(output logic [NO*VL-1:0] d, output logic [NO-1:0] p);
    d = '0;
    p = '0;
    for (int k = 0; k < NO; k++) begin
      for (int j = 0; j < VB; j++) begin
        int         best;
        logic [7:0] b;
        best = -1;
        b    = bus.vrf_data[k*VL + j*8 +: 8];
        for (int i = 0; i < RD; i++) begin
          int         age;
          logic [1:0] bt;
          logic       agn;
          age = (i - int'(bus.rob_head) + RD) % RD;
          bt  = bus.rob_byte_type[(i*VB + j)*2 +: 2];
          agn = (bt == 2'd1 && bus.rob_inactive_one[i]) || (bt == 2'd2 && bus.rob_tail_one[i]);
          if (bus.opn_hit[k*RD + i] && (bt == 2'd0 || agn) && age > best) begin
            best = age;
            b    = agn ? 8'hFF : bus.rob_wdata[i*VL + j*8 +: 8];
          end
        end
        d[k*VL + j*8 +: 8] = b;
      end
      for (int i = 0; i < RD; i++)
        if (bus.opn_hit[k*RD + i] && !bus.rob_done[i]) p[k] = 1'b1;
    end
  endfunction

  logic              m_v;
  logic [NO*VL-1:0]  m_d;
  logic [NO-1:0]     m_p;
  logic              m_ld;
  logic [NO*VL-1:0]  m_nd;
  logic [NO-1:0]     m_np;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v <= 1'b0;
      m_d <= '0;
      m_p <= '0;
    end else begin
      m_ld = bus.in_valid && (!m_v || bus.out_ready) && !bus.flush;
      model(m_nd, m_np);
      if (m_ld) begin
        m_d <= m_nd;
        m_p <= m_np;
      end
      if (bus.flush)          m_v <= 1'b0;
      else if (m_ld)          m_v <= 1'b1;
      else if (bus.out_ready) m_v <= 1'b0;
    end
  end

  // Cycle compare against the model on the inactive edge.
  always @(negedge clk) begin
    chk("cyc_out_valid", NO*VL'(bus.out_valid), NO*VL'(m_v));
    chk("cyc_in_ready", NO*VL'(bus.in_ready), NO*VL'(!m_v || bus.out_ready));
    chk("cyc_out_data", bus.out_data, m_d);
    chk("cyc_out_pending", NO*VL'(bus.out_pending), NO*VL'(m_p));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    bus.flush            = 1'b0;
    bus.rob_head         = '0;
    bus.rob_done         = '1;
    bus.rob_wdata        = '0;
    bus.rob_byte_type    = '0;
    bus.rob_inactive_one = '0;
    bus.rob_tail_one     = '0;
    bus.opn_hit          = '0;
    bus.vrf_data         = '0;
  endtask

  task automatic rand_inputs();
    bus.rob_head         = 3'($urandom);
    bus.rob_done         = 8'($urandom);
    bus.rob_inactive_one = 8'($urandom);
    bus.rob_tail_one     = 8'($urandom);
    for (int w = 0; w < RD*VL/32; w++) bus.rob_wdata[w*32 +: 32] = $urandom;
    for (int w = 0; w < RD*VB*2/32; w++) bus.rob_byte_type[w*32 +: 32] = $urandom;
    for (int w = 0; w < NO*VL/32; w++) bus.vrf_data[w*32 +: 32] = $urandom;
    for (int b = 0; b < NO*RD; b++) bus.opn_hit[b] = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    logic [NO*VL-1:0] exp;
    logic [NO*VL-1:0] held;

    clear();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) step();
    chk("reset_valid", NO*VL'(bus.out_valid), '0);
    chk("reset_data", bus.out_data, '0);
    chk("reset_pending", NO*VL'(bus.out_pending), '0);
    rst_n = 1'b1;
    step();

    // No hits: vs1 straight from VRF bytes 0x00..0x0F.
    clear();
    for (int j = 0; j < VB; j++) bus.vrf_data[j*8 +: 8] = 8'(j);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    exp = '0;
    for (int j = 0; j < VB; j++) exp[j*8 +: 8] = 8'(j);
    chk("vrf_valid", NO*VL'(bus.out_valid), NO*VL'(1));
    chk("vrf_vs1", bus.out_data, exp);
    chk("vrf_pending", NO*VL'(bus.out_pending), '0);

    // Wrap priority: vs2 hits entries 7 (0xAA) and 1 (0x11).
    clear();
    bus.opn_hit[1*RD + 7] = 1'b1;
    bus.opn_hit[1*RD + 1] = 1'b1;
    bus.rob_wdata[7*VL +: VL] = {VB{8'hAA}};
    bus.rob_wdata[1*VL +: VL] = {VB{8'h11}};
    bus.rob_head = 3'd6;          // age(7)=1, age(1)=3 -> entry 1
    bus.in_valid = 1'b1;
    step();
    exp = '0;
    exp[1*VL +: VL] = {VB{8'h11}};
    chk("wrap_head6", bus.out_data, exp);
    bus.rob_head = 3'd0;          // age(7)=7, age(1)=1 -> entry 7
    step();
    exp[1*VL +: VL] = {VB{8'hAA}};
    chk("wrap_head0", bus.out_data, exp);
    bus.rob_head = 3'd2;          // age(7)=5, age(1)=7 -> entry 1
    step();
    bus.in_valid = 1'b0;
    exp[1*VL +: VL] = {VB{8'h11}};
    chk("wrap_head2", bus.out_data, exp);

    // Agnostic fill: vd on entry 3, low half inactive-ones, high half tail-undisturbed.
    clear();
    bus.opn_hit[2*RD + 3] = 1'b1;
    for (int j = 0; j < VB; j++) bus.rob_byte_type[(3*VB + j)*2 +: 2] = (j < 8) ? 2'd1 : 2'd2;
    bus.rob_inactive_one[3] = 1'b1;
    bus.rob_wdata[3*VL +: VL] = {VB{8'h77}};
    bus.vrf_data[2*VL +: VL]  = {VB{8'h55}};
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    exp = '0;
    exp[2*VL +: VL] = {{8{8'h55}}, {8{8'hFF}}};
    chk("agnostic_vd", bus.out_data, exp);

    // Pending: v0 on not-done entry 5.
    clear();
    bus.rob_done[5] = 1'b0;
    bus.opn_hit[3*RD + 5] = 1'b1;
    bus.rob_wdata[5*VL +: VL] = {VB{8'h3C}};
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    exp = '0;
    exp[3*VL +: VL] = {VB{8'h3C}};
    chk("pending_v0", bus.out_data, exp);
    chk("pending_flag", NO*VL'(bus.out_pending), NO*VL'(4'b1000));

    // Backpressure then flush: held data is the pending-test result.
    held = exp;
    bus.out_ready = 1'b0;
    rand_inputs();
    bus.in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("hold_data", bus.out_data, held);
      chk("hold_in_ready", NO*VL'(bus.in_ready), '0);
      chk("hold_valid", NO*VL'(bus.out_valid), NO*VL'(1));
    end
    bus.flush = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_valid", NO*VL'(bus.out_valid), '0);
    chk("flush_no_capture", bus.out_data, held);
    bus.out_ready = 1'b1;

    // Reset while holding a uop.
    clear();
    bus.vrf_data = {(NO*VL/8){8'hA5}};
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_hold_valid", NO*VL'(bus.out_valid), '0);
    chk("rst_hold_data", bus.out_data, '0);
    chk("rst_hold_pending", NO*VL'(bus.out_pending), '0);
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();

    // Randomized traffic, checked every cycle by the compare process.
    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.flush     = ($urandom_range(0, 15) == 0);
      step();
    end
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
